// File: rtl/cache_axi_bridge_pkg.sv
// Shared types and constants for the cache line-fill / writeback AXI bridge.
// Holds the read/write FSM state enums, line geometry and fixed AXI burst fields.
// Every bridge file imports this package; nothing here is configurable per instance.
package cache_axi_bridge_pkg;

    // Line geometry: one cache line is one INCR burst of 32-bit beats.
    localparam int LINE_WORD_NUM = 4;
    localparam int LINE_W        = LINE_WORD_NUM * 32;
    localparam int BEAT_W        = $clog2(LINE_WORD_NUM);
    localparam int LINE_OFF      = $clog2(LINE_WORD_NUM * 4);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORD_NUM - 1);

    // Fixed AXI burst attributes.
    localparam logic [7:0] AXI_LEN        = 8'(LINE_WORD_NUM - 1);
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_WSTRB_ALL  = 4'hF;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2,
        R_DONE = 2'd3
    } r_state_t;

    typedef enum logic [2:0] {
        W_IDLE = 3'd0,
        W_AW   = 3'd1,
        W_DATA = 3'd2,
        W_RESP = 3'd3,
        W_DONE = 3'd4
    } w_state_t;

    // True when both addresses fall in the same cache line.
    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return a[31:LINE_OFF] == b[31:LINE_OFF];
    endfunction

endpackage

// File: rtl/axi_line_wr_ch.sv
// Writeback channel: turns one dirty-line request into an AXI AW + 4-beat W burst + B.
// Latency: AW issued the cycle after acceptance; wr_valid after B (or the cycle after accept when CACHE_WB_POSTED_EN).
// Backpressure: wr_rdy only in W_IDLE; awready/wready/bvalid stall the FSM in place.
// Ports: clk/rst, wr_req/wr_addr/wr_data/wr_rdy/wr_valid (cache side), AW/W/B AXI signals,
//        busy (a write is between acceptance and return to W_IDLE), used for read-after-write ordering.
// Macro CACHE_WB_POSTED_EN: completion pulse is posted at acceptance instead of after B.
module axi_line_wr_ch
    import cache_axi_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [31:0]       wr_addr,
    input  logic [LINE_W-1:0] wr_data,
    output logic              wr_rdy,
    output logic              wr_valid,
    output logic [31:0]       awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready,
    output logic              busy
);

    w_state_t                       w_state_q, w_state_d;
    logic [31:0]                    w_addr_q, w_addr_d;
    logic [LINE_WORD_NUM-1:0][31:0] w_line_q, w_line_d;
    logic [BEAT_W-1:0]              w_beat_q, w_beat_d;

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_line_d  = w_line_q;
        w_beat_d  = w_beat_q;
        wr_rdy    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                wr_rdy = 1'b1;
                if (wr_req) begin
                    w_addr_d  = wr_addr;
                    w_line_d  = wr_data;
                    w_beat_d  = '0;
                    w_state_d = W_AW;
                end
            end
            W_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = (w_beat_q == LAST_BEAT);
                if (wready) begin
                    w_beat_d = w_beat_q + 1'b1;
                    if (w_beat_q == LAST_BEAT) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_state_d = W_DONE;
                end
            end
            W_DONE: begin
                w_state_d = W_IDLE;
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_line_q  <= '0;
            w_beat_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_line_q  <= w_line_d;
            w_beat_q  <= w_beat_d;
        end
    end

    assign awaddr = w_addr_q;
    assign wdata  = w_line_q[w_beat_q];
    assign busy   = (w_state_q != W_IDLE);

`ifdef CACHE_WB_POSTED_EN
    // Posted completion: the cache may reuse the line as soon as it is latched here.
    logic posted_q, posted_d;

    always_comb begin
        posted_d = wr_req && wr_rdy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            posted_q <= 1'b0;
        end else begin
            posted_q <= posted_d;
        end
    end

    assign wr_valid = posted_q;
`else
    assign wr_valid = (w_state_q == W_DONE);
`endif

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI bridge: line fills as AXI INCR read bursts, dirty writebacks as INCR write bursts.
// Latency: fill returns 3 cycles + AXI latency after acceptance; writeback see axi_line_wr_ch.
// Backpressure: rd_rdy/wr_rdy only when the matching FSM idles; a fill to a line being written back waits.
// Ports: clk/rst; rd_req/rd_addr/rd_rdy/ret_valid/ret_data (fill); wr_req/wr_addr/wr_data/wr_rdy/wr_valid
//        (writeback); full AXI AR/R/AW/W/B master signals (bresp not used).
// Macro CACHE_WB_POSTED_EN: posted writeback completion (passed through to axi_line_wr_ch).
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    // fill side
    input  logic              rd_req,
    input  logic [31:0]       rd_addr,
    output logic              rd_rdy,
    output logic              ret_valid,
    output logic [LINE_W-1:0] ret_data,
    // writeback side
    input  logic              wr_req,
    input  logic [31:0]       wr_addr,
    input  logic [LINE_W-1:0] wr_data,
    output logic              wr_rdy,
    output logic              wr_valid,
    // AXI AR / R
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AXI AW / W / B
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    output logic [3:0]        wstrb,
    input  logic              bvalid,
    output logic              bready
);

    assign arlen   = AXI_LEN;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign awlen   = AXI_LEN;
    assign awsize  = AXI_SIZE_4B;
    assign awburst = AXI_BURST_INCR;
    assign wstrb   = AXI_WSTRB_ALL;

    logic wr_busy;

    axi_line_wr_ch u_wr_ch (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_rdy   (wr_rdy),
        .wr_valid (wr_valid),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wlast    (wlast),
        .wvalid   (wvalid),
        .wready   (wready),
        .bvalid   (bvalid),
        .bready   (bready),
        .busy     (wr_busy)
    );

    // A fill must not overtake a writeback of the same line: memory would
    // return stale data. awaddr holds the pending write's line until W_IDLE.
    logic raw_hit;
    assign raw_hit = wr_busy && same_line(rd_addr, awaddr);

    r_state_t                       r_state_q, r_state_d;
    logic [31:0]                    araddr_q, araddr_d;
    logic [BEAT_W-1:0]              r_beat_q, r_beat_d;
    logic [LINE_WORD_NUM-1:0][31:0] r_line_q, r_line_d;

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        r_beat_d  = r_beat_q;
        r_line_d  = r_line_q;
        rd_rdy    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;

        case (r_state_q)
            R_IDLE: begin
                rd_rdy = !raw_hit;
                if (rd_req && !raw_hit) begin
                    araddr_d  = rd_addr;
                    r_beat_d  = '0;
                    r_state_d = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    r_line_d[r_beat_q] = rdata;
                    r_beat_d           = r_beat_q + 1'b1;
                    // rlast ends the burst even if it arrives early; the
                    // untouched words keep their previous contents.
                    if (rlast) begin
                        r_state_d = R_DONE;
                    end
                end
            end
            R_DONE: begin
                ret_valid = 1'b1;
                r_state_d = R_IDLE;
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            r_beat_q  <= '0;
            r_line_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            r_beat_q  <= r_beat_d;
            r_line_q  <= r_line_d;
        end
    end

    assign araddr   = araddr_q;
    assign ret_data = r_line_q;

endmodule
